// File: rtl/spi_burst_sequencer_if.sv
// MMIO master/slave bundle between the burst sequencer and the spi_master address decoder.
interface spi_burst_sequencer_if;
  logic        m_valid;
  logic        m_write;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata;
  logic        m_ready;

  modport master (
    output m_valid,
    output m_write,
    output m_addr,
    output m_wdata,
    output m_wstrb,
    input  m_rdata,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_write,
    input  m_addr,
    input  m_wdata,
    input  m_wstrb,
    output m_rdata,
    output m_ready
  );
endinterface

// File: rtl/spi_burst_sequencer.sv
// Runs a whole N-byte SPI block transfer by mastering spi_master's MMIO port: setup writes,
// then per byte TX fetch, DATA write, STATUS polling and DATA read into the RX buffer.
module spi_burst_sequencer #(
  parameter logic [31:0] SPI_BASE   = 32'h8000_0050,
  parameter int unsigned MAX_LEN    = 512,
  parameter int unsigned POLL_LIMIT = 1000
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [9:0]                   cmd_len,
  input  logic [7:0]                   cmd_ctrl,
  input  logic                         cmd_abort,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [9:0]                   xfer_cnt,
  spi_burst_sequencer_if.master        mmio,
  output logic [8:0]                   tx_rd_addr,
  input  logic [7:0]                   tx_rd_data,
  output logic                         rx_we,
  output logic [8:0]                   rx_addr,
  output logic [7:0]                   rx_data
);

  localparam logic [31:0] OffCtrl   = 32'h0;
  localparam logic [31:0] OffData   = 32'h4;
  localparam logic [31:0] OffStatus = 32'h8;
  localparam logic [31:0] OffCs     = 32'hC;
  localparam logic [31:0] OffBurst  = 32'h10;
  localparam logic [9:0]  MaxLen    = 10'(MAX_LEN);
  localparam logic [9:0]  PollLast  = 10'(POLL_LIMIT - 1);

  typedef enum logic [3:0] {
    StIdle,
    StWrCtrl,
    StWrCs0,
    StWrBurst,
    StFetch,
    StWrData,
    StPoll,
    StRdData,
    StWrCs1,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [9:0]  len_q, len_d;
  logic [7:0]  ctrl_q, ctrl_d;
  logic        err_q, err_d;
  logic [9:0]  xfer_cnt_q, xfer_cnt_d;
  logic [9:0]  poll_cnt_q, poll_cnt_d;
  logic        abort_q, abort_d;
  logic        gap_q, gap_d;
  logic        done_q, done_d;
  logic        rx_we_q, rx_we_d;
  logic [8:0]  rx_addr_q, rx_addr_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        m_valid_q, m_valid_d;
  logic        m_write_q, m_write_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic [3:0]  m_wstrb_q, m_wstrb_d;

  logic        beat_req;
  logic        beat_write;
  logic [31:0] beat_addr;
  logic [31:0] beat_wdata;
  logic        beat_done;
  logic        abortable;
  logic        abort_pend;
  logic        illegal;
  logic [9:0]  next_cnt;

  logic unused_rdata;
  assign unused_rdata = ^mmio.m_rdata[31:8];

  // Beat descriptor for the current state; only launched when no beat is in flight.
  always_comb begin
    beat_req   = 1'b0;
    beat_write = 1'b1;
    beat_addr  = SPI_BASE;
    beat_wdata = 32'h0;
    unique case (state_q)
      StWrCtrl: begin
        beat_req   = 1'b1;
        beat_addr  = SPI_BASE + OffCtrl;
        beat_wdata = {24'h0, ctrl_q};
      end
      StWrCs0: begin
        beat_req  = 1'b1;
        beat_addr = SPI_BASE + OffCs;
      end
      StWrBurst: begin
        beat_req   = 1'b1;
        beat_addr  = SPI_BASE + OffBurst;
        beat_wdata = {22'h0, len_q};
      end
      StWrData: begin
        beat_req   = 1'b1;
        beat_addr  = SPI_BASE + OffData;
        beat_wdata = {24'h0, tx_rd_data};
      end
      StPoll: begin
        beat_req   = 1'b1;
        beat_write = 1'b0;
        beat_addr  = SPI_BASE + OffStatus;
      end
      StRdData: begin
        beat_req   = 1'b1;
        beat_write = 1'b0;
        beat_addr  = SPI_BASE + OffData;
      end
      StWrCs1: begin
        beat_req   = 1'b1;
        beat_addr  = SPI_BASE + OffCs;
        beat_wdata = 32'h1;
      end
      default: ;
    endcase
  end

  assign beat_done  = m_valid_q & mmio.m_ready;
  assign abortable  = (state_q != StIdle) && (state_q != StWrCs1) && (state_q != StDone);
  assign abort_pend = abort_q | cmd_abort;
  assign next_cnt   = xfer_cnt_q + 10'd1;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    ctrl_d     = ctrl_q;
    err_d      = err_q;
    xfer_cnt_d = xfer_cnt_q;
    poll_cnt_d = poll_cnt_q;
    abort_d    = abort_q;
    gap_d      = 1'b0;
    illegal    = 1'b0;
    rx_we_d    = 1'b0;
    rx_addr_d  = rx_addr_q;
    rx_data_d  = rx_data_q;
    m_valid_d  = m_valid_q;
    m_write_d  = m_write_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    m_wstrb_d  = m_wstrb_q;

    if (abortable && cmd_abort) begin
      abort_d = 1'b1;
    end

    if (state_q == StIdle) begin
      if (cmd_valid) begin
        if (cmd_len == 10'd0 || cmd_len > MaxLen) begin
          err_d   = 1'b1;
          illegal = 1'b1;
        end else begin
          state_d    = StWrCtrl;
          len_d      = cmd_len;
          ctrl_d     = cmd_ctrl;
          err_d      = 1'b0;
          xfer_cnt_d = 10'd0;
          abort_d    = 1'b0;
        end
      end
    end else if (state_q == StDone) begin
      state_d = StIdle;
    end else if (beat_done) begin
      m_valid_d = 1'b0;
      gap_d     = 1'b1;
      case (state_q)
        StWrCtrl:  state_d = StWrCs0;
        StWrCs0:   state_d = StWrBurst;
        StWrBurst: state_d = StFetch;
        StWrData: begin
          state_d    = StPoll;
          poll_cnt_d = 10'd0;
        end
        StPoll: begin
          if (!mmio.m_rdata[0]) begin
            state_d = StRdData;
          end else if (poll_cnt_q == PollLast) begin
            err_d   = 1'b1;
            state_d = StWrCs1;
          end else begin
            poll_cnt_d = poll_cnt_q + 10'd1;
          end
        end
        StRdData: begin
          rx_we_d   = 1'b1;
          rx_addr_d = xfer_cnt_q[8:0];
          rx_data_d = mmio.m_rdata[7:0];
          if (xfer_cnt_q < len_q) begin
            xfer_cnt_d = next_cnt;
          end
          state_d = (next_cnt >= len_q) ? StWrCs1 : StFetch;
        end
        StWrCs1:   state_d = StDone;
        default:   ;
      endcase
      // The finished beat stands; abort only redirects what comes next.
      if (abortable && abort_pend) begin
        err_d   = 1'b1;
        state_d = StWrCs1;
      end
    end else if (abortable && abort_pend && !m_valid_q) begin
      err_d   = 1'b1;
      state_d = StWrCs1;
      gap_d   = 1'b1;
    end else if (state_q == StFetch) begin
      state_d = StWrData;
    end else if (beat_req && !m_valid_q && !gap_q) begin
      m_valid_d = 1'b1;
      m_write_d = beat_write;
      m_addr_d  = beat_addr;
      m_wdata_d = beat_wdata;
      m_wstrb_d = beat_write ? 4'b1111 : 4'b0000;
    end

    done_d = (state_d == StDone) | illegal;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      len_q      <= 10'd0;
      ctrl_q     <= 8'd0;
      err_q      <= 1'b0;
      xfer_cnt_q <= 10'd0;
      poll_cnt_q <= 10'd0;
      abort_q    <= 1'b0;
      gap_q      <= 1'b0;
      done_q     <= 1'b0;
      rx_we_q    <= 1'b0;
      rx_addr_q  <= 9'd0;
      rx_data_q  <= 8'd0;
      m_valid_q  <= 1'b0;
      m_write_q  <= 1'b0;
      m_addr_q   <= 32'h0;
      m_wdata_q  <= 32'h0;
      m_wstrb_q  <= 4'h0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      ctrl_q     <= ctrl_d;
      err_q      <= err_d;
      xfer_cnt_q <= xfer_cnt_d;
      poll_cnt_q <= poll_cnt_d;
      abort_q    <= abort_d;
      gap_q      <= gap_d;
      done_q     <= done_d;
      rx_we_q    <= rx_we_d;
      rx_addr_q  <= rx_addr_d;
      rx_data_q  <= rx_data_d;
      m_valid_q  <= m_valid_d;
      m_write_q  <= m_write_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      m_wstrb_q  <= m_wstrb_d;
    end
  end

  assign cmd_ready    = (state_q == StIdle);
  assign busy         = (state_q != StIdle);
  assign done         = done_q;
  assign err          = err_q;
  assign xfer_cnt     = xfer_cnt_q;
  assign tx_rd_addr   = xfer_cnt_q[8:0];
  assign rx_we        = rx_we_q;
  assign rx_addr      = rx_addr_q;
  assign rx_data      = rx_data_q;
  assign mmio.m_valid = m_valid_q;
  assign mmio.m_write = m_write_q;
  assign mmio.m_addr  = m_addr_q;
  assign mmio.m_wdata = m_wdata_q;
  assign mmio.m_wstrb = m_wstrb_q;

endmodule

// File: tb/tb_spi_burst_sequencer.sv
// Directed bench for spi_burst_sequencer with a small spi_master register model on the MMIO port.
module tb_spi_burst_sequencer;
  localparam logic [31:0] Base   = 32'h8000_0050;
  localparam int          LogMax = 8192;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [9:0] cmd_len = 10'd0;
  logic [7:0] cmd_ctrl = 8'd0;
  logic       cmd_abort = 1'b0;
  logic       busy, done, err;
  logic [9:0] xfer_cnt;
  logic [8:0] tx_rd_addr;
  logic [7:0] tx_rd_data;
  logic       rx_we;
  logic [8:0] rx_addr;
  logic [7:0] rx_data;

  always #5 clk = ~clk;

  spi_burst_sequencer_if bus ();

  spi_burst_sequencer dut (
    .clk        (clk),
    .resetn     (resetn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_len    (cmd_len),
    .cmd_ctrl   (cmd_ctrl),
    .cmd_abort  (cmd_abort),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .xfer_cnt   (xfer_cnt),
    .mmio       (bus),
    .tx_rd_addr (tx_rd_addr),
    .tx_rd_data (tx_rd_data),
    .rx_we      (rx_we),
    .rx_addr    (rx_addr),
    .rx_data    (rx_data)
  );

  int checks = 0;
  int errors = 0;

  // TX buffer (sync read) and RX capture log
  logic [7:0] tx_mem [512];
  always @(posedge clk) tx_rd_data <= tx_mem[tx_rd_addr];

  int         rx_cnt = 0;
  logic [8:0] rx_log_a [LogMax];
  logic [7:0] rx_log_d [LogMax];
  always @(posedge clk) begin
    if (rx_we) begin
      if (rx_cnt < LogMax) begin
        rx_log_a[rx_cnt] <= rx_addr;
        rx_log_d[rx_cnt] <= rx_data;
      end
      rx_cnt <= rx_cnt + 1;
    end
  end

  int done_cnt = 0;
  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  // spi_master register model: DATA loops back, STATUS busy for busy_polls reads per byte
  logic        stuck = 1'b0;
  logic        rand_wait = 1'b0;
  int          busy_polls = 1;
  int          beat_n = 0, status_reads = 0, stable_err = 0, gap_err = 0, strb_err = 0;
  int          wait_cnt = 0, wait_tgt = 0, stat_cnt = 0;
  logic [7:0]  data_reg = 8'h0;
  logic        burst_mode = 1'b0;
  logic        hold_v = 1'b0, hold_w = 1'b0, post_beat = 1'b0;
  logic [31:0] hold_a = 32'h0, hold_d = 32'h0;
  logic        log_w [LogMax];
  logic [31:0] log_a [LogMax];
  logic [31:0] log_d [LogMax];

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.m_ready <= 1'b0;
      bus.m_rdata <= 32'h0;
      wait_cnt    <= 0;
      hold_v      <= 1'b0;
      post_beat   <= 1'b0;
    end else begin
      hold_v    <= bus.m_valid && !bus.m_ready;
      hold_w    <= bus.m_write;
      hold_a    <= bus.m_addr;
      hold_d    <= bus.m_wdata;
      post_beat <= bus.m_valid && bus.m_ready;
      if (hold_v && (!bus.m_valid || bus.m_addr != hold_a || bus.m_wdata != hold_d ||
                     bus.m_write != hold_w))
        stable_err <= stable_err + 1;
      if (post_beat && bus.m_valid) gap_err <= gap_err + 1;
      if (bus.m_ready) begin
        bus.m_ready <= 1'b0;
      end else if (bus.m_valid) begin
        if (wait_cnt < wait_tgt) begin
          wait_cnt <= wait_cnt + 1;
        end else begin
          wait_cnt    <= 0;
          wait_tgt    <= rand_wait ? int'($urandom_range(7, 0)) : 0;
          bus.m_ready <= 1'b1;
          if (bus.m_wstrb !== (bus.m_write ? 4'hF : 4'h0)) strb_err <= strb_err + 1;
          if (beat_n < LogMax) begin
            log_w[beat_n] <= bus.m_write;
            log_a[beat_n] <= bus.m_addr;
            log_d[beat_n] <= bus.m_write ? bus.m_wdata : 32'h0;
          end
          beat_n <= beat_n + 1;
          if (bus.m_write) begin
            bus.m_rdata <= 32'h0;
            case (bus.m_addr - Base)
              32'h4: begin
                data_reg <= bus.m_wdata[7:0];
                stat_cnt <= 0;
              end
              32'hC:  if (bus.m_wdata[0]) burst_mode <= 1'b0;
              32'h10: burst_mode <= (bus.m_wdata != 32'h0);
              default: ;
            endcase
          end else begin
            case (bus.m_addr - Base)
              32'h8: begin
                bus.m_rdata  <= {31'h2BC_DEF0, stuck || (stat_cnt < busy_polls)};
                stat_cnt     <= stat_cnt + 1;
                status_reads <= status_reads + 1;
              end
              32'h4:   bus.m_rdata <= {24'hA5C3E1, data_reg};
              default: bus.m_rdata <= 32'h0;
            endcase
          end
        end
      end
    end
  end

  // Expected beat sequence
  logic        exp_w [LogMax];
  logic [31:0] exp_a [LogMax];
  logic [31:0] exp_d [LogMax];
  int          exp_n = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_push(input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_w[exp_n] = w;
    exp_a[exp_n] = a;
    exp_d[exp_n] = d;
    exp_n++;
  endtask

  task automatic build_exp(input int len, input logic [7:0] ctrl, input int polls);
    exp_n = 0;
    exp_push(1'b1, Base + 32'h0, {24'h0, ctrl});
    exp_push(1'b1, Base + 32'hC, 32'h0);
    exp_push(1'b1, Base + 32'h10, 32'(len));
    for (int i = 0; i < len; i++) begin
      exp_push(1'b1, Base + 32'h4, {24'h0, tx_mem[i]});
      for (int p = 0; p <= polls; p++) exp_push(1'b0, Base + 32'h8, 32'h0);
      exp_push(1'b0, Base + 32'h4, 32'h0);
    end
    exp_push(1'b1, Base + 32'hC, 32'h1);
  endtask

  task automatic check_log(input string tag, input int b0, input int n, input bit whole);
    int bad;
    bad = 0;
    if (whole) chk({tag, "_beats"}, beat_n - b0, exp_n);
    for (int k = 0; k < n; k++) begin
      if (b0 + k < LogMax) begin
        if (log_w[b0+k] !== exp_w[k] || log_a[b0+k] !== exp_a[k] || log_d[b0+k] !== exp_d[k])
          bad++;
      end
    end
    chk({tag, "_order"}, bad, 0);
  endtask

  task automatic check_rx(input string tag, input int r0, input int len);
    int bad;
    bad = 0;
    chk({tag, "_rx_cnt"}, rx_cnt - r0, len);
    for (int i = 0; i < len; i++) begin
      if (rx_log_a[r0+i] !== 9'(i) || rx_log_d[r0+i] !== tx_mem[i]) bad++;
    end
    chk({tag, "_rx_data"}, bad, 0);
  endtask

  task automatic start_cmd(input logic [9:0] len, input logic [7:0] ctrl);
    int n;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    cmd_valid = 1'b1;
    cmd_len   = len;
    cmd_ctrl  = ctrl;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0, input int limit);
    int n;
    n = 0;
    while (done_cnt == d0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(tag, (done_cnt != d0), 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, b0, r0, s0, b_ab, n, busy_seen;
    logic [9:0] ill_len [2];
    for (int i = 0; i < 512; i++) tx_mem[i] = i[7:0];
    ill_len[0] = 10'd0;
    ill_len[1] = 10'd513;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_write", bus.m_write, 0);
    chk("rst_m_addr", bus.m_addr, 0);
    chk("rst_m_wstrb", bus.m_wstrb, 0);
    chk("rst_xfer_cnt", xfer_cnt, 0);
    chk("rst_tx_rd_addr", tx_rd_addr, 0);
    chk("rst_rx_we", rx_we, 0);
    resetn = 1'b1;
    @(negedge clk);
    chk("idle_cmd_ready", cmd_ready, 1);

    // 4-byte transfer, one busy STATUS read per byte
    busy_polls = 1;
    build_exp(4, 8'h00, 1);
    b0 = beat_n; d0 = done_cnt; r0 = rx_cnt;
    start_cmd(10'd4, 8'h00);
    chk("t4_busy", busy, 1);
    chk("t4_cmd_ready", cmd_ready, 0);
    wait_done("t4_done", d0, 2000);
    chk("t4_done_once", done_cnt - d0, 1);
    check_log("t4", b0, exp_n, 1'b1);
    check_rx("t4", r0, 4);
    chk("t4_xfer_cnt", xfer_cnt, 4);
    chk("t4_err", err, 0);
    chk("t4_idle", busy, 0);

    // full 512-byte sector
    build_exp(512, 8'h23, 1);
    b0 = beat_n; d0 = done_cnt; r0 = rx_cnt;
    start_cmd(10'd512, 8'h23);
    wait_done("t512_done", d0, 20000);
    check_log("t512", b0, exp_n, 1'b1);
    check_rx("t512", r0, 512);
    chk("t512_xfer_cnt", xfer_cnt, 512);
    chk("t512_tx_rd_addr", tx_rd_addr, 0);
    chk("t512_burst_mode", burst_mode, 0);
    chk("t512_err", err, 0);

    // illegal lengths: no beats, err, done pulse, never busy
    for (int k = 0; k < 2; k++) begin
      d0 = done_cnt; b0 = beat_n;
      start_cmd(ill_len[k], 8'h11);
      busy_seen = 0;
      repeat (4) begin
        if (busy) busy_seen = 1;
        @(negedge clk);
      end
      chk($sformatf("ill%0d_err", ill_len[k]), err, 1);
      chk($sformatf("ill%0d_done", ill_len[k]), done_cnt - d0, 1);
      chk($sformatf("ill%0d_beats", ill_len[k]), beat_n - b0, 0);
      chk($sformatf("ill%0d_busy", ill_len[k]), busy_seen, 0);
    end

    // random wait states; also clears the sticky err on accept
    rand_wait  = 1'b1;
    busy_polls = 2;
    build_exp(16, 8'h41, 2);
    b0 = beat_n; d0 = done_cnt; r0 = rx_cnt;
    start_cmd(10'd16, 8'h41);
    chk("rw_err_cleared", err, 0);
    wait_done("rw_done", d0, 5000);
    check_log("rw", b0, exp_n, 1'b1);
    check_rx("rw", r0, 16);
    chk("rw_xfer_cnt", xfer_cnt, 16);
    chk("rw_err", err, 0);
    rand_wait  = 1'b0;
    busy_polls = 1;

    // STATUS stuck busy -> poll timeout
    stuck = 1'b1;
    b0 = beat_n; d0 = done_cnt; r0 = rx_cnt; s0 = status_reads;
    start_cmd(10'd2, 8'h05);
    wait_done("to_done", d0, 10000);
    chk("to_status_reads", status_reads - s0, 1000);
    chk("to_err", err, 1);
    chk("to_last_w", log_w[beat_n-1], 1);
    chk("to_last_addr", log_a[beat_n-1], Base + 32'hC);
    chk("to_last_data", log_d[beat_n-1], 1);
    chk("to_beats", beat_n - b0, 1005);
    chk("to_rx_cnt", rx_cnt - r0, 0);
    chk("to_done_once", done_cnt - d0, 1);
    stuck = 1'b0;

    // abort while byte 10 of 64 is polling
    busy_polls = 1;
    build_exp(64, 8'h00, 1);
    b0 = beat_n; d0 = done_cnt;
    start_cmd(10'd64, 8'h00);
    n = 0;
    while (!(xfer_cnt == 10'd9 && bus.m_valid && bus.m_addr == Base + 32'h8) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("ab_reached_byte10", (n < 3000), 1);
    cmd_abort = 1'b1;
    b_ab = beat_n;
    wait_done("ab_done", d0, 2000);
    cmd_abort = 1'b0;
    check_log("ab_prefix", b0, b_ab - b0, 1'b0);
    chk("ab_err", err, 1);
    chk("ab_xfer_le10", (xfer_cnt <= 10'd10) && (xfer_cnt >= 10'd9), 1);
    chk("ab_beats_after", (beat_n - b_ab) <= 2, 1);
    chk("ab_last_addr", log_a[beat_n-1], Base + 32'hC);
    chk("ab_last_data", log_d[beat_n-1], 1);
    chk("ab_done_once", done_cnt - d0, 1);
    chk("ab_idle", busy, 0);

    // abort held in IDLE is ignored and not remembered
    b0 = beat_n;
    cmd_abort = 1'b1;
    repeat (3) @(negedge clk);
    cmd_abort = 1'b0;
    chk("abidle_busy", busy, 0);
    chk("abidle_beats", beat_n - b0, 0);
    build_exp(4, 8'h00, 1);
    d0 = done_cnt; r0 = rx_cnt;
    start_cmd(10'd4, 8'h00);
    wait_done("abidle_done", d0, 2000);
    check_log("abidle", b0, exp_n, 1'b1);
    chk("abidle_err", err, 0);
    chk("abidle_xfer_cnt", xfer_cnt, 4);

    // async reset mid-beat drops m_valid at once
    start_cmd(10'd8, 8'h00);
    n = 0;
    while (!bus.m_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    #2 resetn = 1'b0;
    #1;
    chk("arst_m_valid", bus.m_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_xfer_cnt", xfer_cnt, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("arst_cmd_ready", cmd_ready, 1);

    chk("bus_stable", stable_err, 0);
    chk("bus_gap", gap_err, 0);
    chk("bus_wstrb", strb_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
